// File: rtl/eth_pcs_block_lock.sv
// rtl/eth_pcs_block_lock.sv - 64b/66b PCS block lock state machine
`timescale 1ns/1ps

module eth_pcs_block_lock #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 4,
    parameter int W_SYNC       = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic [W_SYNC-1:0] i_sync_hdr,
    output logic              o_slip,
    output logic              o_block_lock,
    output logic              o_sh_valid
);

    // Counters are sized to hold their terminal value so they never wrap.
    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        LOCK_INIT,
        TEST_SH,
        SLIP_WAIT_ST
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    sh_cnt_q, sh_cnt_d, sh_cnt_inc;
    logic [INV_W-1:0]    invld_q, invld_d, invld_inc;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
    logic                lock_q, lock_d;
    logic                slip_q, slip_d;
    logic                valid_q, valid_d;
    logic                hdr_valid;

    // Only 01 and 10 are legal sync headers (data / control block).
    assign hdr_valid = i_sync_hdr[1] ^ i_sync_hdr[0];

    assign o_slip       = slip_q;
    assign o_block_lock = lock_q;
    assign o_sh_valid   = valid_q;

    // State and output registers; reset forces all outputs low at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= LOCK_INIT;
            sh_cnt_q <= '0;
            invld_q  <= '0;
            wait_q   <= '0;
            lock_q   <= 1'b0;
            slip_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_cnt_q <= sh_cnt_d;
            invld_q  <= invld_d;
            wait_q   <= wait_d;
            lock_q   <= lock_d;
            slip_q   <= slip_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: one header is judged per enabled cycle.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        invld_d    = invld_q;
        wait_d     = wait_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        valid_d    = valid_q;
        sh_cnt_inc = sh_cnt_q + CNT_W'(1);
        invld_inc  = invld_q + INV_W'(!hdr_valid);
        wait_inc   = wait_q + WAIT_W'(1);

        case (state_q)
            LOCK_INIT: begin
                sh_cnt_d = '0;
                invld_d  = '0;
                wait_d   = '0;
                lock_d   = 1'b0;
                state_d  = TEST_SH;
            end
            TEST_SH: begin
                if (i_clk_en) begin
                    valid_d  = hdr_valid;
                    sh_cnt_d = sh_cnt_inc;
                    invld_d  = invld_inc;
                    if (!lock_q) begin
                        // Acquiring: any bad header means wrong alignment.
                        if (!hdr_valid) begin
                            slip_d   = 1'b1;
                            sh_cnt_d = '0;
                            invld_d  = '0;
                            wait_d   = '0;
                            state_d  = SLIP_WAIT_ST;
                        end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                            lock_d   = 1'b1;
                            sh_cnt_d = '0;
                            invld_d  = '0;
                        end
                    end else begin
                        // Locked: too many bad headers wins over window end.
                        if (invld_inc == INV_W'(SH_INVLD_MAX)) begin
                            lock_d   = 1'b0;
                            slip_d   = 1'b1;
                            sh_cnt_d = '0;
                            invld_d  = '0;
                            wait_d   = '0;
                            state_d  = SLIP_WAIT_ST;
                        end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                            sh_cnt_d = '0;
                            invld_d  = '0;
                        end
                    end
                end
            end
            SLIP_WAIT_ST: begin
                // Let the gearbox settle; headers here are not judged.
                if (i_clk_en) begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(SLIP_WAIT)) begin
                        wait_d   = '0;
                        sh_cnt_d = '0;
                        invld_d  = '0;
                        state_d  = TEST_SH;
                    end
                end
            end
            default: begin
                state_d = LOCK_INIT;
            end
        endcase
    end

endmodule

// File: doc/eth_pcs_block_lock.md
ETH_PCS_BLOCK_LOCK -- requirements
Module: eth_pcs_block_lock

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64, meaning the number of headers per test window.
REQ-002 SHALL have parameter SH_INVLD_MAX, default 16, meaning the invalid headers per window that drop lock.
REQ-003 SHALL have parameter SLIP_WAIT, default 4, meaning the enabled cycles ignored after a slip.
REQ-004 SHALL have port i_clk  input  1  sole clock.
REQ-005 SHALL have port i_reset  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port i_clk_en  input  1  RX gearbox header-valid strobe; one header is evaluated per cycle with i_clk_en=1.
REQ-007 SHALL have port i_sync_hdr  input  W_SYNC (2)  66b sync header from the RX gearbox.
REQ-008 SHALL have port o_slip  output  1  one-cycle pulse; RX gearbox shifts its alignment by one bit.
REQ-009 SHALL have port o_block_lock  output  1  block lock achieved.
REQ-010 SHALL have port o_sh_valid  output  1  registered: the last evaluated header was valid.

Function
REQ-011 A header SHALL be valid iff i_sync_hdr is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-012 Headers SHALL be evaluated only when i_clk_en=1; with i_clk_en=0, state, counters and outputs SHALL hold, except that o_slip SHALL be 0.
REQ-013 The FSM SHALL have the states LOCK_INIT, TEST_SH, SLIP_WAIT_ST.
REQ-014 LOCK_INIT SHALL clear sh_cnt and sh_invld_cnt, SHALL set o_block_lock=0, and SHALL go to TEST_SH on the next cycle.
REQ-015 In TEST_SH, each evaluated header SHALL increment sh_cnt, and each invalid header SHALL also increment sh_invld_cnt; sh_cnt SHALL be sized for SH_CNT_MAX and SHALL never wrap.
REQ-016 In TEST_SH with o_block_lock=0, an invalid header SHALL assert o_slip on the next cycle, clear both counters and enter SLIP_WAIT_ST.
REQ-017 In TEST_SH with o_block_lock=0, when the SH_CNT_MAX-th header is valid with sh_invld_cnt=0, o_block_lock SHALL set and both counters SHALL clear.
REQ-018 In TEST_SH with o_block_lock=1, when sh_invld_cnt reaches SH_INVLD_MAX, o_block_lock SHALL clear, o_slip SHALL pulse, the counters SHALL clear and the FSM SHALL enter SLIP_WAIT_ST.
REQ-019 In TEST_SH with o_block_lock=1, when sh_cnt reaches SH_CNT_MAX with sh_invld_cnt<SH_INVLD_MAX, both counters SHALL clear and lock SHALL remain asserted.
REQ-020 Simultaneous events: if the SH_CNT_MAX-th header is also the SH_INVLD_MAX-th invalid header, the slip (REQ-018) SHALL take priority.
REQ-021 o_slip SHALL be high for exactly one i_clk cycle per slip event.
REQ-022 SLIP_WAIT_ST SHALL ignore SLIP_WAIT evaluated headers, then return to TEST_SH with cleared counters; o_sh_valid SHALL hold during this state.
REQ-023 Latency: o_block_lock and o_slip SHALL update on the i_clk edge after the deciding header is sampled, i.e. one cycle of latency.

Reset
REQ-024 While i_reset=1, the block SHALL drive o_slip=0, o_block_lock=0 and o_sh_valid=0, SHALL clear all counters and SHALL hold the FSM in LOCK_INIT.
REQ-025 Reset asserted mid-window or mid-slip-wait SHALL abort immediately, with no residual o_slip pulse.
REQ-026 After release, the block SHALL restart acquisition from LOCK_INIT.

Verification
REQ-027 The bench SHALL cover: 64 consecutive valid headers (2'b01/2'b10 alternating), i_clk_en=1 -> o_block_lock=1 one cycle after the 64th, and o_slip never asserted.
REQ-028 The bench SHALL cover: unlocked, header 2'b11 at index 10 -> o_slip single pulse, then 4 ignored headers, then counting resumes from 0, and lock needs 64 fresh valid headers.
REQ-029 The bench SHALL cover: locked, 15 invalid headers within a 64-header window -> lock held and counters cleared at the 64th; 16 invalid in the next window -> o_block_lock=0 and o_slip pulse.
REQ-030 The bench SHALL cover: locked, 16th invalid header as the 64th header -> slip taken, o_block_lock=0.
REQ-031 The bench SHALL cover: i_clk_en toggling 1/0 with a gap every 33 cycles during acquisition -> lock after exactly 64 enabled headers, and gap cycles change nothing.
REQ-032 The bench SHALL cover: i_reset asserted asynchronously while locked and during SLIP_WAIT_ST -> all outputs 0 immediately, and reacquisition requires 64 valid headers.
